// File: rtl/pc_branch_ctrl_if.sv
// rtl/pc_branch_ctrl_if.sv - run-control and branch bus for pc_branch_ctrl
// BACK_CT is present only when BACK_BRANCH_CT_EN is defined.
interface pc_branch_ctrl_if #(
  parameter int PC_W = 10,
  parameter int CT_W = 16
);
  logic            START;
  logic            HALT_REQ;
  logic            BRANCH;
  logic [3:0]      bOFFSET;
  logic            bSIGN;
  logic [PC_W-1:0] PC;
  logic            RUNNING;
  logic            DONE;
  logic [CT_W-1:0] CYCLE_CT;
`ifdef BACK_BRANCH_CT_EN
  logic [CT_W-1:0] BACK_CT;

  modport master (
    output START, HALT_REQ, BRANCH, bOFFSET, bSIGN,
    input  PC, RUNNING, DONE, CYCLE_CT, BACK_CT
  );
  modport slave (
    input  START, HALT_REQ, BRANCH, bOFFSET, bSIGN,
    output PC, RUNNING, DONE, CYCLE_CT, BACK_CT
  );
`else
  modport master (
    output START, HALT_REQ, BRANCH, bOFFSET, bSIGN,
    input  PC, RUNNING, DONE, CYCLE_CT
  );
  modport slave (
    input  START, HALT_REQ, BRANCH, bOFFSET, bSIGN,
    output PC, RUNNING, DONE, CYCLE_CT
  );
`endif
endinterface

// File: rtl/pc_branch_ctrl.sv
// rtl/pc_branch_ctrl.sv - program counter, branch and start/halt run control
// Optional backward-branch counter enabled by BACK_BRANCH_CT_EN.
module pc_branch_ctrl #(
  parameter int PC_W = 10,
  parameter int CT_W = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  pc_branch_ctrl_if.slave    bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10,
    BAD    = 2'b11
  } state_t;

  state_t          state, state_n;
  logic            start_q;
  logic [PC_W-1:0] pc, pc_n;
  logic [CT_W-1:0] ct, ct_n, ct_inc;
  logic [PC_W-1:0] off_ext;

  assign off_ext = {{(PC_W-4){1'b0}}, bus.bOFFSET};
  assign ct_inc  = (&ct) ? ct : ct + CT_W'(1);

`ifdef BACK_BRANCH_CT_EN
  logic [CT_W-1:0] bct, bct_n, bct_inc;
  assign bct_inc = (&bct) ? bct : bct + CT_W'(1);
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      start_q <= 1'b0;
      pc      <= '0;
      ct      <= '0;
`ifdef BACK_BRANCH_CT_EN
      bct     <= '0;
`endif
    end else begin
      state   <= state_n;
      start_q <= bus.START;
      pc      <= pc_n;
      ct      <= ct_n;
`ifdef BACK_BRANCH_CT_EN
      bct     <= bct_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ct_n    = ct;
`ifdef BACK_BRANCH_CT_EN
    bct_n   = bct;
`endif
    // START=1 is a restart from any state; it clears PC and all counters.
    if (bus.START || state == BAD) begin
      state_n = IDLE;
      pc_n    = '0;
      ct_n    = '0;
`ifdef BACK_BRANCH_CT_EN
      bct_n   = '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_q) begin
            state_n = RUN;
            pc_n    = '0;
          end
        end
        RUN: begin
          ct_n = ct_inc;
          if (bus.HALT_REQ) begin
            state_n = HALTED;
          end else if (bus.BRANCH) begin
            pc_n = bus.bSIGN ? pc - off_ext : pc + off_ext;
`ifdef BACK_BRANCH_CT_EN
            if (bus.bSIGN) bct_n = bct_inc;
`endif
          end else begin
            pc_n = pc + PC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.PC       = pc;
  assign bus.RUNNING  = (state == RUN);
  assign bus.DONE     = (state == HALTED);
  assign bus.CYCLE_CT = ct;
`ifdef BACK_BRANCH_CT_EN
  assign bus.BACK_CT  = bct;
`endif
endmodule

// File: tb/tb_pc_branch_ctrl.sv
// tb/tb_pc_branch_ctrl.sv - scoreboard bench for pc_branch_ctrl
// BACK_CT is checked only when BACK_BRANCH_CT_EN is defined.
module tb_pc_branch_ctrl;
  logic clk;
  logic rst;

  pc_branch_ctrl_if #(.PC_W(10), .CT_W(16)) bus ();

  pc_branch_ctrl #(.PC_W(10), .CT_W(16)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    int          id;
    logic [9:0]  pc;
    logic        run;
    logic        done;
    logic [15:0] ct;
    logic [15:0] bct;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   step_id = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: actual=%0d required=%0d", name, id, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc", e.id, 32'(bus.PC), 32'(e.pc));
      chk("running", e.id, 32'(bus.RUNNING), 32'(e.run));
      chk("done", e.id, 32'(bus.DONE), 32'(e.done));
      chk("cycle_ct", e.id, 32'(bus.CYCLE_CT), 32'(e.ct));
`ifdef BACK_BRANCH_CT_EN
      chk("back_ct", e.id, 32'(bus.BACK_CT), 32'(e.bct));
`endif
    end
  end

  task automatic step(input logic r, input logic s, input logic h, input logic b,
                      input logic [3:0] o, input logic sg,
                      input logic [9:0] epc, input logic erun, input logic edone,
                      input logic [15:0] ect, input logic [15:0] ebct);
    exp_t e;
    rst          = r;
    bus.START    = s;
    bus.HALT_REQ = h;
    bus.BRANCH   = b;
    bus.bOFFSET  = o;
    bus.bSIGN    = sg;
    @(posedge clk);
    step_id++;
    e.id = step_id; e.pc = epc; e.run = erun; e.done = edone; e.ct = ect; e.bct = ebct;
    sb.push_back(e);
    #1;
  endtask

  initial begin
    int ect;
    // reset, then START=0 without prior high stays idle
    step(1,0,0,0,0,0, 10'd0,0,0, 16'd0,16'd0);
    step(1,0,0,0,0,0, 10'd0,0,0, 16'd0,16'd0);
    step(0,0,0,0,0,0, 10'd0,0,0, 16'd0,16'd0);
    for (int i = 0; i < 3; i++) step(0,1,0,0,0,0, 10'd0,0,0, 16'd0,16'd0);
    step(0,0,0,0,0,0, 10'd0,1,0, 16'd0,16'd0);
    for (int i = 1; i <= 5; i++) step(0,0,0,0,0,0, 10'(i),1,0, 16'(i),16'd0);
    // branches from PC=5
    step(0,0,0,1,4'd4,0, 10'd9,1,0, 16'd6,16'd0);
    step(0,0,0,1,4'd3,1, 10'd6,1,0, 16'd7,16'd1);
    step(0,0,0,1,4'd1,0, 10'd7,1,0, 16'd8,16'd1);
    step(0,0,0,1,4'd0,0, 10'd7,1,0, 16'd9,16'd1);
    // wrap both ways
    step(0,0,0,1,4'd8,1, 10'd1023,1,0, 16'd10,16'd2);
    step(0,0,0,1,4'd2,0, 10'd1,1,0, 16'd11,16'd2);
    step(0,0,0,1,4'd5,1, 10'd1020,1,0, 16'd12,16'd3);
    step(0,0,0,1,4'd15,0, 10'd11,1,0, 16'd13,16'd3);
    step(0,0,0,0,0,0, 10'd12,1,0, 16'd14,16'd3);
    // halt beats a simultaneous backward branch
    step(0,0,1,1,4'd4,1, 10'd12,0,1, 16'd15,16'd3);
    for (int i = 0; i < 10; i++)
      step(0,0,1'($urandom),1'($urandom),4'($urandom),1'($urandom), 10'd12,0,1, 16'd15,16'd3);
    // restart from HALTED, walk to PC=40, restart mid-run
    step(0,1,0,0,0,0, 10'd0,0,0, 16'd0,16'd0);
    step(0,0,0,0,0,0, 10'd0,1,0, 16'd0,16'd0);
    for (int i = 1; i <= 40; i++) step(0,0,0,0,0,0, 10'(i),1,0, 16'(i),16'd0);
    step(0,1,0,0,0,0, 10'd0,0,0, 16'd0,16'd0);
    step(0,0,0,0,0,0, 10'd0,1,0, 16'd0,16'd0);
    for (int i = 1; i <= 3; i++) step(0,0,0,0,0,0, 10'(i),1,0, 16'(i),16'd0);
    step(1,0,0,0,0,0, 10'd0,0,0, 16'd0,16'd0);
    step(0,0,0,0,0,0, 10'd0,0,0, 16'd0,16'd0);
    // 4-instruction loop, backward branch taken 7 times, then halt at PC=3
    step(0,1,0,0,0,0, 10'd0,0,0, 16'd0,16'd0);
    step(0,0,0,0,0,0, 10'd0,1,0, 16'd0,16'd0);
    ect = 0;
    for (int it = 0; it < 7; it++) begin
      for (int k = 0; k < 3; k++) begin
        ect++;
        step(0,0,0,0,0,0, 10'(k+1),1,0, 16'(ect),16'(it));
      end
      ect++;
      step(0,0,0,1,4'd3,1, 10'd0,1,0, 16'(ect),16'(it+1));
    end
    for (int k = 0; k < 3; k++) begin
      ect++;
      step(0,0,0,0,0,0, 10'(k+1),1,0, 16'(ect),16'd7);
    end
    step(0,0,1,0,0,0, 10'd3,0,1, 16'd32,16'd7);
    step(0,0,0,0,0,0, 10'd3,0,1, 16'd32,16'd7);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_branch_ctrl.md
Name: pc_branch_ctrl

Overview:
- Program-counter and run-control block for the single-cycle core.
- Consumes the branch result the ALU produces for a branch instruction (a 4-bit offset magnitude plus a sign bit) and the decoder's halt indication. Produces the next instruction address.
- Runs the start/done handshake with the testbench: hold in reset-like idle while START is high, run after START falls, raise DONE on halt.
- Also counts executed cycles for performance reporting.

Parameters:
- PC_W, 10, width of the program counter; instruction memory depth is 2^PC_W.
- CT_W, 16, width of the cycle counter.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  testbench start level. High holds the PC at 0; the falling edge begins execution.
- HALT_REQ  input  1  decoder flags the current instruction as halt.
- BRANCH  input  1  current instruction is a branch; bOFFSET/bSIGN are valid.
- bOFFSET  input  4  branch offset magnitude from the ALU.
- bSIGN  input  1  branch direction from the ALU: 1 = backward (subtract), 0 = forward (add).
- PC  output  PC_W  current instruction address, registered.
- RUNNING  output  1  high while in RUN.
- DONE  output  1  high while in HALTED.
- CYCLE_CT  output  CT_W  number of RUN cycles since the last start.

Behaviour:
- Single clock CLK. Reset is synchronous, active-high, on port RESET.
- States and encodings: IDLE (00), RUN (01), HALTED (10). Encoding 11 is illegal and returns to IDLE on the next edge.
- Reset values: state IDLE, PC 0, RUNNING 0, DONE 0, CYCLE_CT 0. RESET overrides every other input.
- IDLE:
  - While START=1: PC=0, CYCLE_CT=0.
  - When START was 1 on the previous edge and is 0 on this edge, go to RUN with PC=0. This uses a registered copy of START, cleared by RESET.
  - START=0 with no prior high leaves the block in IDLE.
- RUN, per edge, in priority order:
  - START=1 → IDLE, PC=0. This is a restart and may happen mid-program.
  - HALT_REQ=1 → HALTED. PC holds the halt instruction's address. Halt wins over a simultaneous BRANCH.
  - BRANCH=1 with bSIGN=0 → PC <= PC + bOFFSET.
  - BRANCH=1 with bSIGN=1 → PC <= PC − bOFFSET.
  - Otherwise → PC <= PC + 1.
  - CYCLE_CT increments on every RUN edge, including the halting edge.
- Branch arithmetic:
  - Modulo 2^PC_W. Forward past the top wraps to low addresses; backward below 0 wraps to the top.
  - bOFFSET is zero-extended to PC_W before the add or subtract.
  - A branch with bOFFSET=0 holds the PC. This is legal and spins until HALT_REQ or START.
  - A not-taken branch arrives as bOFFSET=1, bSIGN=0. It is handled as an ordinary branch and gives PC+1; no separate taken input is needed.
- HALTED: PC and CYCLE_CT hold and DONE=1. Only START=1 (→ IDLE) or RESET leaves this state.
- CYCLE_CT saturates at all-ones; it does not wrap.
- Outputs are pure register outputs; there is no combinational path from inputs to PC.
- RUNNING and DONE decode from state and are never both 1.
- Latency: an input sampled on edge n is reflected in PC after edge n. The next instruction fetch uses the new PC in cycle n+1.

Optional Feature:
- Macro: BACK_BRANCH_CT_EN.
- When defined:
  - Adds output BACK_CT (CT_W bits), counting RUN edges with BRANCH=1, bSIGN=1 and no HALT_REQ or START. This gives the loop-iteration count.
  - Cleared by RESET and while START=1; saturates at all-ones; held in HALTED.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- RESET=1 for 2 edges, then START high 3 edges, then low → PC=0, RUNNING=1 one edge after START falls. PC reads 1, 2, 3 on the following edges with BRANCH=0.
- In RUN at PC=5: BRANCH=1, bOFFSET=4, bSIGN=0 → PC=9. Then BRANCH=1, bOFFSET=3, bSIGN=1 → PC=6. Then bOFFSET=1, bSIGN=0 (not taken) → PC=7.
- Wrap: at PC=1023, BRANCH=1, bOFFSET=2, bSIGN=0 → PC=1. Then BRANCH=1, bOFFSET=5, bSIGN=1 → PC=1020.
- At PC=12, HALT_REQ=1 and BRANCH=1 (bOFFSET=4, bSIGN=1) together → PC stays 12, DONE=1, RUNNING=0. Ten further edges with random inputs and START=0 leave PC and CYCLE_CT unchanged.
- Mid-run START=1 at PC=40, CYCLE_CT=40 → next edge IDLE, PC=0, CYCLE_CT=0. START low → RUN from PC=0. RESET=1 mid-run gives the same result plus RUNNING=0.
- With BACK_BRANCH_CT_EN: a loop of 4 instructions ending in a backward branch (bOFFSET=3, bSIGN=1) taken 7 times, then a halt → BACK_CT=7. CYCLE_CT equals the total number of RUN edges counted through the halting edge.
